// File: rtl/path_tracer.sv
// Walks a predecessor table back from dst to src through a one-cycle-latency RAM,
// then streams the recovered path src..dst out through a LIFO.
module path_tracer #(
  parameter int NODE_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NODE_WIDTH-1:0] src,
  input  logic [NODE_WIDTH-1:0] dst,
  output logic [NODE_WIDTH-1:0] mem_addr,
  input  logic [NODE_WIDTH-1:0] mem_q,
  output logic [NODE_WIDTH-1:0] out_node,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [NODE_WIDTH:0]   path_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int DEPTH = 2 ** NODE_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    FINISH
  } state_t;

  state_t state, state_d;

  logic [NODE_WIDTH-1:0] stack [DEPTH];
  logic [NODE_WIDTH:0]   sp;
  logic [NODE_WIDTH:0]   depth;
  logic [NODE_WIDTH-1:0] cur;
  logic [NODE_WIDTH-1:0] src_q;
  logic [NODE_WIDTH-1:0] top_idx;
  logic                  err_q;
  logic                  fail;
  logic                  pop;
  logic                  pop_last;

  assign top_idx = NODE_WIDTH'(sp - 1'b1);

  // A self-loop means dst is unreachable; a full LIFO means the chain cycles.
  assign fail = (mem_q == cur) ||
                (depth == (NODE_WIDTH+1)'(DEPTH));

  assign pop      = (state == EMIT) && out_ready;
  assign pop_last = pop && (sp == 1);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_d = (dst == src) ? EMIT : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fail)
          state_d = FINISH;
        else if (mem_q == src_q)
          state_d = EMIT;
        else
          state_d = ISSUE;
      end
      EMIT: begin
        if (pop_last)
          state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sp       <= '0;
      depth    <= '0;
      cur      <= '0;
      src_q    <= '0;
      err_q    <= 1'b0;
      path_len <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          if (start) begin
            cur   <= dst;
            src_q <= src;
            sp    <= 1;
            depth <= 1;
            err_q <= 1'b0;
          end
        end
        WAIT: begin
          if (fail) begin
            err_q <= 1'b1;
          end else begin
            cur   <= mem_q;
            sp    <= sp + 1'b1;
            depth <= depth + 1'b1;
          end
        end
        EMIT: begin
          if (pop)
            sp <= sp - 1'b1;
          if (pop_last)
            path_len <= depth;
        end
        FINISH: begin
          sp    <= '0;
          depth <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset: sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && start)
        stack[0] <= dst;
      else if (state == WAIT && !fail)
        stack[sp[NODE_WIDTH-1:0]] <= mem_q;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign error     = done && err_q;
  assign out_valid = (state == EMIT);
  assign out_node  = out_valid ? stack[top_idx] : '0;
  assign out_last  = out_valid && (sp == 1);
  assign mem_addr  = (state == ISSUE || state == WAIT) ? cur : '0;

endmodule

// File: tb/tb_path_tracer.sv
// Bench for path_tracer: table of traces against a modelled predecessor RAM,
// plus hand sequences for stalls, busy starts and resets.
module tb_path_tracer;

  logic       clk = 0;
  logic       reset;
  logic       start;
  logic [4:0] src, dst;
  logic [4:0] mem_addr, mem_q;
  logic [4:0] out_node;
  logic       out_valid, out_ready, out_last;
  logic [5:0] path_len;
  logic       busy, done, error;

  logic [4:0] ram [32];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int last_len  = 0;

  logic [4:0] exp_q [$];

  typedef struct {
    logic [4:0] src;
    logic [4:0] dst;
    int         n;
    logic [4:0] nodes [4];
    bit         err;
    int         len;
  } vec_t;

  vec_t vecs [5];

  path_tracer #(.NODE_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src(src), .dst(dst),
    .mem_addr(mem_addr), .mem_q(mem_q),
    .out_node(out_node), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .path_len(path_len), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= ram[mem_addr];

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(int v, bit stall, bit poke);
    int cyc, first, pops, ecnt, emitted;
    bit finished, mem_act, prev_stall;
    logic [4:0] held, exp_n;
    bit [3:0] pat;
    pat = 4'b1001;
    if (!vecs[v].err)
      for (int i = 0; i < vecs[v].n; i++)
        exp_q.push_back(vecs[v].nodes[i]);
    @(negedge clk);
    src = vecs[v].src;
    dst = vecs[v].dst;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1; first = -1; pops = 0; ecnt = 0; emitted = 0;
    finished = 0; mem_act = 0; prev_stall = 0; held = 0;
    while (cyc < 300 && !finished) begin
      if (poke && cyc == 2) begin
        start = 1; src = 7; dst = 7;
      end else begin
        start = 0; src = vecs[v].src; dst = vecs[v].dst;
      end
      out_ready = stall ? pat[3 - (ecnt % 4)] : 1'b1;
      #1;
      if (mem_addr != 0) mem_act = 1;
      if (prev_stall)
        chk($sformatf("v%0d hold", v), out_node, held);
      prev_stall = 0;
      if (out_valid) begin
        if (first < 0) first = cyc;
        ecnt++;
        if (out_ready) begin
          emitted++;
          if (exp_q.size() == 0) begin
            chk($sformatf("v%0d extra", v), 1, 0);
          end else begin
            exp_n = exp_q.pop_front();
            chk($sformatf("v%0d node", v), out_node, exp_n);
            chk($sformatf("v%0d last", v), out_last,
                int'(exp_q.size() == 0));
          end
        end else begin
          prev_stall = 1;
          held = out_node;
        end
      end
      if (done) begin
        finished = 1;
        chk($sformatf("v%0d error", v), error, vecs[v].err);
        chk($sformatf("v%0d busy@done", v), busy, 1);
        if (!vecs[v].err) last_len = vecs[v].len;
        chk($sformatf("v%0d path_len", v), path_len, last_len);
        chk($sformatf("v%0d emitted", v), emitted,
            vecs[v].err ? 0 : vecs[v].n);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) chk($sformatf("v%0d timeout", v), 0, 1);
    start = 0;
    if (v == 0 && !stall) chk("latency", first, 5);
    if (vecs[v].src == vecs[v].dst) chk("no mem", mem_act, 0);
    chk($sformatf("v%0d queue", v), exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    #1;
    chk($sformatf("v%0d busy idle", v), busy, 0);
    chk($sformatf("v%0d done once", v), done, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 5'(i);
    ram[3] = 1;  ram[1] = 0;
    ram[5] = 5;
    ram[2] = 4;  ram[4] = 2;
    ram[10] = 20; ram[20] = 6; ram[6] = 9;

    vecs[0] = '{src: 0, dst: 3, n: 3, nodes: '{0, 1, 3, 0}, err: 0, len: 3};
    vecs[1] = '{src: 7, dst: 7, n: 1, nodes: '{7, 0, 0, 0}, err: 0, len: 1};
    vecs[2] = '{src: 0, dst: 5, n: 0, nodes: '{0, 0, 0, 0}, err: 1, len: 0};
    vecs[3] = '{src: 0, dst: 2, n: 0, nodes: '{0, 0, 0, 0}, err: 1, len: 0};
    vecs[4] = '{src: 9, dst: 10, n: 4, nodes: '{9, 6, 20, 10}, err: 0, len: 4};

    reset = 1; start = 0; src = 0; dst = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst valid", out_valid, 0);
    chk("rst node", out_node, 0);
    chk("rst last", out_last, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst len", path_len, 0);
    reset = 0;

    for (int v = 0; v < 5; v++) run_vec(v, 0, 0);

    // stalled handshake plus a start pulse while busy
    run_vec(0, 1, 1);

    // reset during WAIT of the second hop
    @(negedge clk);
    src = 0; dst = 3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst valid", out_valid, 0);
    chk("mid rst done", done, 0);
    reset = 0;
    last_len = 0;
    chk("mid rst len", path_len, 0);
    run_vec(0, 0, 0);

    // reset wins over start
    @(negedge clk);
    reset = 1; start = 1; src = 0; dst = 3;
    @(negedge clk);
    reset = 0; start = 0;
    #1;
    chk("rst prio busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
